// File: rtl/fb_writer_if.sv
// Pixel-stream, reader-sync and frame-buffer write port bundle for fb_writer.
// The slave modport is the writer's view; the master modport is the upstream/harness view.
interface fb_writer_if;
    logic [4:0]  red;
    logic [4:0]  green;
    logic [4:0]  blue;
    logic [18:0] index;
    logic        valid;
    logic        rd_vsync;
    logic        bram_we;
    logic [19:0] bram_addr;
    logic [14:0] bram_din;
    logic        rd_bank;
    logic        frame_done;
    logic [7:0]  drop_cnt;
    logic        err_index;

    modport slave (
        input  red, green, blue, index, valid, rd_vsync,
        output bram_we, bram_addr, bram_din, rd_bank, frame_done, drop_cnt, err_index
    );

    modport master (
        output red, green, blue, index, valid, rd_vsync,
        input  bram_we, bram_addr, bram_din, rd_bank, frame_done, drop_cnt, err_index
    );
endinterface

// File: rtl/fb_writer.sv
// Frame-buffer writer: takes indexed RGB555 pixels and writes them into one of two BRAM banks.
// Define FB_DOUBLE_BUFFER_EN for ping-pong banks swapped on rd_vsync; otherwise a single bank.
module fb_writer #(
    parameter int FRAME_PIXELS = 307200
) (
    input  logic        clk,
    input  logic        RESET,
    fb_writer_if.slave  fb
);

`ifdef FB_DOUBLE_BUFFER_EN
    localparam bit DOUBLE_BUF = 1'b1;
`else
    localparam bit DOUBLE_BUF = 1'b0;
`endif

    localparam logic [19:0] NPIX     = 20'(FRAME_PIXELS);
    localparam logic [18:0] LAST_IDX = 19'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    state_t      state_q;
    logic        wr_bank_q;
    logic        rd_bank_q;
    logic [18:0] exp_idx_q;
    logic        bram_we_q;
    logic [19:0] bram_addr_q;
    logic [14:0] bram_din_q;
    logic        frame_done_q;
    logic [7:0]  drop_cnt_q;
    logic        err_index_q;

    logic in_range;
    logic accept;
    logic last_pix;

    // A pixel is written only when it opens a frame from IDLE or arrives while a frame is in flight.
    always_comb begin
        in_range = ({1'b0, fb.index} < NPIX);
        accept   = fb.valid && in_range &&
                   (((state_q == IDLE) && (fb.index == 19'd0)) || (state_q == WRITE));
        last_pix = (fb.index == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q      <= IDLE;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= DOUBLE_BUF;
            exp_idx_q    <= '0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_din_q   <= '0;
            frame_done_q <= 1'b0;
            drop_cnt_q   <= '0;
            err_index_q  <= 1'b0;
        end else begin
            bram_we_q    <= 1'b0;
            frame_done_q <= 1'b0;

            // Out-of-range indices are flagged whatever the state and are never written.
            if (fb.valid && !in_range) begin
                err_index_q <= 1'b1;
            end
            if (fb.valid && in_range && (state_q == WRITE) && (fb.index != exp_idx_q)) begin
                err_index_q <= 1'b1;
            end

            if (accept) begin
                bram_we_q   <= 1'b1;
                bram_addr_q <= {wr_bank_q, fb.index};
                bram_din_q  <= {fb.red, fb.green, fb.blue};
                if (last_pix) begin
                    frame_done_q <= 1'b1;
                    exp_idx_q    <= '0;
                    state_q      <= DOUBLE_BUF ? WAIT_SWAP : IDLE;
                end else begin
                    exp_idx_q <= fb.index + 19'd1;
                    state_q   <= WRITE;
                end
            end

            if (state_q == WAIT_SWAP) begin
                if (fb.valid && (fb.index == 19'd0) && (drop_cnt_q != 8'hFF)) begin
                    drop_cnt_q <= drop_cnt_q + 8'd1;
                end
                // The reader has finished with the old bank, so hand it the freshly written one.
                if (fb.rd_vsync) begin
                    state_q <= IDLE;
                    if (DOUBLE_BUF) begin
                        rd_bank_q <= wr_bank_q;
                        wr_bank_q <= ~wr_bank_q;
                    end
                end
            end
        end
    end

    assign fb.bram_we    = bram_we_q;
    assign fb.bram_addr  = bram_addr_q;
    assign fb.bram_din   = bram_din_q;
    assign fb.rd_bank    = rd_bank_q;
    assign fb.frame_done = frame_done_q;
    assign fb.drop_cnt   = drop_cnt_q;
    assign fb.err_index  = err_index_q;

endmodule
